// File: rtl/keccak_squeeze.sv
// Keccak squeeze stage: streams rate-sized blocks of the permuted state as 256-bit beats.
// Optional XOF mode (unbounded output, stop_i input) is enabled with KECCAK_SQUEEZE_XOF_EN.
package keccak_pkg;
   parameter int unsigned DWIDTH     = 256;
   parameter int unsigned KEEP_WIDTH = 32;
   parameter int unsigned LANE_SIZE  = 64;
   parameter int unsigned ROW_SIZE   = 5;
   parameter int unsigned COL_SIZE   = 5;
   parameter int unsigned RATE_WIDTH = 11;
endpackage

module keccak_squeeze
   import keccak_pkg::*;
#(
   parameter int unsigned OUT_LEN_WIDTH = 16
) (
   input  logic                                               clk,
   input  logic                                               rst_n,
   input  logic                                               start_i,
   input  logic [RATE_WIDTH-1:0]                              rate_i,
   input  logic [OUT_LEN_WIDTH-1:0]                           out_len_i,
   input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]   state_array_i,
`ifdef KECCAK_SQUEEZE_XOF_EN
   input  logic                                               stop_i,
`endif
   output logic                                               perm_req_o,
   input  logic                                               perm_done_i,
   output logic [DWIDTH-1:0]                                  m_data_o,
   output logic [KEEP_WIDTH-1:0]                              m_keep_o,
   output logic                                               m_last_o,
   output logic                                               m_valid_o,
   input  logic                                               m_ready_i,
   output logic                                               busy_o,
   output logic                                               done_o
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      EMIT      = 2'd1,
      PERM_WAIT = 2'd2
   } state_t;

   state_t                     r_state;
   logic [RATE_WIDTH-1:0]      r_rate_bytes;
   logic [RATE_WIDTH-1:0]      r_offset;
   logic [OUT_LEN_WIDTH-1:0]   r_remaining;
   logic [DWIDTH-1:0]          r_data;
   logic [KEEP_WIDTH-1:0]      r_keep;
   logic                       r_last;
   logic                       r_valid;
   logic                       r_perm_req;
   logic                       r_busy;
   logic                       r_done;

   logic [RATE_WIDTH-1:0]      w_src_off;
   logic [RATE_WIDTH-1:0]      w_src_rate;
   logic [OUT_LEN_WIDTH-1:0]   w_src_rem;
   logic [31:0]                w_avail;
   logic [31:0]                w_n;
   logic [31:0]                w_lane_base;
   logic [31:0]                w_rate_lanes;
   logic [DWIDTH-1:0]          w_data;
   logic [KEEP_WIDTH-1:0]      w_keep;
   logic                       w_last;
   logic [RATE_WIDTH-1:0]      w_next_off;
   logic [OUT_LEN_WIDTH-1:0]   w_next_rem;
   logic                       w_unbounded;
   logic                       w_zero_len;

`ifdef KECCAK_SQUEEZE_XOF_EN
   logic                       r_unbounded;
   assign w_unbounded = (r_state == IDLE) ? (out_len_i == '0) : r_unbounded;
   assign w_zero_len  = 1'b0;
`else
   assign w_unbounded = 1'b0;
   assign w_zero_len  = (out_len_i == '0);
`endif

   // r_offset/r_remaining hold the position after the presented beat, so the
   // next beat can be built combinationally and loaded on acceptance without a bubble.
   always_comb begin
      w_src_off  = r_offset;
      w_src_rem  = r_remaining;
      w_src_rate = r_rate_bytes;
      if (r_state == IDLE) begin
         w_src_off  = '0;
         w_src_rem  = out_len_i;
         w_src_rate = rate_i >> 3;
      end else if (r_state == PERM_WAIT) begin
         w_src_off  = '0;
      end
   end

   always_comb begin
      w_avail = 32'(w_src_rate) - 32'(w_src_off);
      w_n     = 32'd32;
      if (w_avail < w_n) w_n = w_avail;
      if (!w_unbounded && (32'(w_src_rem) < w_n)) w_n = 32'(w_src_rem);
   end

   assign w_lane_base  = 32'(w_src_off) >> 3;
   assign w_rate_lanes = 32'(w_src_rate) >> 3;
   assign w_last       = !w_unbounded && (32'(w_src_rem) == w_n);
   assign w_next_off   = w_src_off + RATE_WIDTH'(w_n);
   assign w_next_rem   = w_src_rem - OUT_LEN_WIDTH'(w_n);

   always_comb begin
      w_keep = '0;
      for (int unsigned b = 0; b < KEEP_WIDTH; b++) begin
         w_keep[b] = (b < w_n);
      end
   end

   // Lane L lives at state_array_i[L%5][L/5]; lanes past the rate read as zero.
   always_comb begin
      w_data = '0;
      for (int unsigned k = 0; k < DWIDTH / LANE_SIZE; k++) begin
         for (int unsigned x = 0; x < ROW_SIZE; x++) begin
            for (int unsigned y = 0; y < COL_SIZE; y++) begin
               if (((x + ROW_SIZE * y) == (w_lane_base + k)) &&
                   ((w_lane_base + k) < w_rate_lanes)) begin
                  w_data[LANE_SIZE*k +: LANE_SIZE] = state_array_i[x][y];
               end
            end
         end
      end
      for (int unsigned b = 0; b < KEEP_WIDTH; b++) begin
         if (!w_keep[b]) w_data[8*b +: 8] = 8'h00;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_rate_bytes <= '0;
         r_offset     <= '0;
         r_remaining  <= '0;
         r_data       <= '0;
         r_keep       <= '0;
         r_last       <= 1'b0;
         r_valid      <= 1'b0;
         r_perm_req   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
`ifdef KECCAK_SQUEEZE_XOF_EN
         r_unbounded  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
`ifdef KECCAK_SQUEEZE_XOF_EN
         if (stop_i && (r_state != IDLE)) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_keep     <= '0;
            r_data     <= '0;
            r_perm_req <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
         end else
`endif
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  if (w_zero_len) begin
                     r_done <= 1'b1;
                  end else begin
                     r_rate_bytes <= w_src_rate;
`ifdef KECCAK_SQUEEZE_XOF_EN
                     r_unbounded  <= w_unbounded;
`endif
                     r_data       <= w_data;
                     r_keep       <= w_keep;
                     r_last       <= w_last;
                     r_valid      <= 1'b1;
                     r_offset     <= w_next_off;
                     r_remaining  <= w_next_rem;
                     r_busy       <= 1'b1;
                     r_state      <= EMIT;
                  end
               end
            end
            EMIT: begin
               if (r_valid && m_ready_i) begin
                  if (r_last) begin
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                  end else if (r_offset == r_rate_bytes) begin
                     r_valid    <= 1'b0;
                     r_perm_req <= 1'b1;
                     r_state    <= PERM_WAIT;
                  end else begin
                     r_data      <= w_data;
                     r_keep      <= w_keep;
                     r_last      <= w_last;
                     r_offset    <= w_next_off;
                     r_remaining <= w_next_rem;
                  end
               end
            end
            PERM_WAIT: begin
               if (perm_done_i) begin
                  r_perm_req  <= 1'b0;
                  r_data      <= w_data;
                  r_keep      <= w_keep;
                  r_last      <= w_last;
                  r_valid     <= 1'b1;
                  r_offset    <= w_next_off;
                  r_remaining <= w_next_rem;
                  r_state     <= EMIT;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign m_data_o   = r_data;
   assign m_keep_o   = r_keep;
   assign m_last_o   = r_last;
   assign m_valid_o  = r_valid;
   assign perm_req_o = r_perm_req;
   assign busy_o     = r_busy;
   assign done_o     = r_done;

endmodule

// File: tb/tb_keccak_squeeze.sv
// Directed bench for keccak_squeeze (default build, XOF disabled).
module tb_keccak_squeeze;

   logic                           clk;
   logic                           rst_n;
   logic                           start_i;
   logic [10:0]                    rate_i;
   logic [15:0]                    out_len_i;
   logic [4:0][4:0][63:0]          st;
   logic                           perm_req_o;
   logic                           perm_done_i;
   logic [255:0]                   m_data_o;
   logic [31:0]                    m_keep_o;
   logic                           m_last_o;
   logic                           m_valid_o;
   logic                           m_ready_i;
   logic                           busy_o;
   logic                           done_o;

   int total = 0;
   int bad   = 0;

   keccak_squeeze #(.OUT_LEN_WIDTH(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .rate_i        (rate_i),
      .out_len_i     (out_len_i),
      .state_array_i (st),
      .perm_req_o    (perm_req_o),
      .perm_done_i   (perm_done_i),
      .m_data_o      (m_data_o),
      .m_keep_o      (m_keep_o),
      .m_last_o      (m_last_o),
      .m_valid_o     (m_valid_o),
      .m_ready_i     (m_ready_i),
      .busy_o        (busy_o),
      .done_o        (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] lane_val(input int lane, input logic inv);
      logic [31:0] l;
      l = lane;
      lane_val = 64'h0123_4567_89AB_CDEF ^ {8{l[7:0]}} ^ {64{inv}};
   endfunction

   function automatic logic [255:0] exp_data(input int base, input int n);
      logic [255:0] d;
      d = '0;
      for (int k = 0; k < 4; k++)
         if (base + k < 25) d[64*k +: 64] = lane_val(base + k, 1'b0);
      for (int b = 0; b < 32; b++)
         if (b >= n) d[8*b +: 8] = 8'h00;
      exp_data = d;
   endfunction

   task automatic fill(input logic inv);
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++)
            st[x][y] = lane_val(x + 5 * y, inv);
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic beat(input string tag, input int base, input int n,
                       input logic [31:0] keep, input logic last);
      chk({tag, ".valid"}, 256'(m_valid_o), 256'(1'b1));
      chk({tag, ".keep"},  256'(m_keep_o),  256'(keep));
      chk({tag, ".last"},  256'(m_last_o),  256'(last));
      chk({tag, ".data"},  m_data_o,        exp_data(base, n));
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; start_i = 1'b0; rate_i = '0; out_len_i = '0;
      perm_done_i = 1'b0; m_ready_i = 1'b1;
      fill(1'b0);
      #22;
      chk("rst.valid", 256'(m_valid_o),  '0);
      chk("rst.keep",  256'(m_keep_o),   '0);
      chk("rst.data",  m_data_o,         '0);
      chk("rst.last",  256'(m_last_o),   '0);
      chk("rst.preq",  256'(perm_req_o), '0);
      chk("rst.busy",  256'(busy_o),     '0);
      chk("rst.done",  256'(done_o),     '0);

      // single beat, rate 1088, 32 bytes
      rst_n = 1'b1; start_i = 1'b1; rate_i = 11'd1088; out_len_i = 16'd32;
      cyc(); start_i = 1'b0;
      beat("A0", 0, 32, 32'hFFFF_FFFF, 1'b1);
      chk("A0.busy", 256'(busy_o), 256'(1'b1));
      chk("A0.preq", 256'(perm_req_o), '0);
      chk("A0.done", 256'(done_o), '0);
      cyc();
      chk("A.valid_off", 256'(m_valid_o), '0);
      chk("A.done",      256'(done_o), 256'(1'b1));
      chk("A.busy_off",  256'(busy_o), '0);
      chk("A.preq",      256'(perm_req_o), '0);
      cyc();
      chk("A.done_pulse", 256'(done_o), '0);

      // zero-length request
      start_i = 1'b1; out_len_i = 16'd0;
      cyc(); start_i = 1'b0;
      chk("Z.valid", 256'(m_valid_o), '0);
      chk("Z.done",  256'(done_o), 256'(1'b1));
      chk("Z.busy",  256'(busy_o), '0);
      cyc();
      chk("Z.done_pulse", 256'(done_o), '0);
      chk("Z.valid2",     256'(m_valid_o), '0);

      // rate 1344, 180 bytes, with a 3-cycle stall
      start_i = 1'b1; rate_i = 11'd1344; out_len_i = 16'd180;
      cyc(); start_i = 1'b0;
      beat("B0", 0, 32, 32'hFFFF_FFFF, 1'b0);
      cyc();
      beat("B1", 4, 32, 32'hFFFF_FFFF, 1'b0);
      m_ready_i = 1'b0; start_i = 1'b1; out_len_i = 16'd0; perm_done_i = 1'b1; fill(1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         beat("B1.stall", 4, 32, 32'hFFFF_FFFF, 1'b0);
         chk("B1.stall.done", 256'(done_o), '0);
         chk("B1.stall.busy", 256'(busy_o), 256'(1'b1));
      end
      m_ready_i = 1'b1; start_i = 1'b0; perm_done_i = 1'b0; fill(1'b0);
      rate_i = 11'd1088; out_len_i = 16'd5;
      cyc();
      beat("B2", 8, 32, 32'hFFFF_FFFF, 1'b0);
      cyc();
      beat("B3", 12, 32, 32'hFFFF_FFFF, 1'b0);
      cyc();
      beat("B4", 16, 32, 32'hFFFF_FFFF, 1'b0);
      cyc();
      beat("B5", 20, 8, 32'h0000_00FF, 1'b0);
      cyc();
      chk("B.pw.valid", 256'(m_valid_o), '0);
      chk("B.pw.preq",  256'(perm_req_o), 256'(1'b1));
      chk("B.pw.busy",  256'(busy_o), 256'(1'b1));
      cyc();
      chk("B.pw.preq2", 256'(perm_req_o), 256'(1'b1));
      chk("B.pw.valid2", 256'(m_valid_o), '0);
      perm_done_i = 1'b1;
      cyc(); perm_done_i = 1'b0;
      beat("B6", 0, 12, 32'h0000_0FFF, 1'b1);
      chk("B6.preq", 256'(perm_req_o), '0);
      cyc();
      chk("B.done",      256'(done_o), 256'(1'b1));
      chk("B.valid_off", 256'(m_valid_o), '0);
      chk("B.busy_off",  256'(busy_o), '0);

      // reset during PERM_WAIT, then a fresh stream
      cyc();
      start_i = 1'b1; rate_i = 11'd1088; out_len_i = 16'd200;
      cyc(); start_i = 1'b0;
      beat("D0", 0, 32, 32'hFFFF_FFFF, 1'b0);
      cyc(); cyc(); cyc();
      beat("D3", 12, 32, 32'hFFFF_FFFF, 1'b0);
      cyc();
      beat("D4", 16, 8, 32'h0000_00FF, 1'b0);
      cyc();
      chk("D.pw.preq", 256'(perm_req_o), 256'(1'b1));
      chk("D.pw.valid", 256'(m_valid_o), '0);
      #3 rst_n = 1'b0;
      #1;
      chk("D.rst.preq",  256'(perm_req_o), '0);
      chk("D.rst.busy",  256'(busy_o), '0);
      chk("D.rst.valid", 256'(m_valid_o), '0);
      chk("D.rst.keep",  256'(m_keep_o), '0);
      #2;
      rst_n = 1'b1; start_i = 1'b1; rate_i = 11'd1088; out_len_i = 16'd40;
      cyc(); start_i = 1'b0;
      beat("E0", 0, 32, 32'hFFFF_FFFF, 1'b0);
      cyc();
      beat("E1", 4, 8, 32'h0000_00FF, 1'b1);
      chk("E1.preq", 256'(perm_req_o), '0);
      cyc();
      chk("E.done",  256'(done_o), 256'(1'b1));
      chk("E.valid", 256'(m_valid_o), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/keccak_squeeze.md
KECCAK_SQUEEZE -- requirements
Module: keccak_squeeze

Interface
REQ-001 SHALL take parameters from keccak_pkg: DWIDTH=256, KEEP_WIDTH=32, LANE_SIZE=64, ROW_SIZE=COL_SIZE=5, RATE_WIDTH; OUT_LEN_WIDTH default 16, output length in bytes.
REQ-002 Ports; one clock; reset asynchronous, active-low:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start_i  in  1  single-cycle pulse; begins a squeeze
- rate_i  in  RATE_WIDTH  rate in bits (1088, 1344, …), sampled on start
- out_len_i  in  OUT_LEN_WIDTH  total output bytes, sampled on start
- state_array_i  in  [ROW][COL][LANE]  permuted state, indexed [x][y]
- perm_req_o  out  1  request one Keccak-f permutation
- perm_done_i  in  1  permutation complete; state_array_i valid
- m_data_o  out  DWIDTH  output beat
- m_keep_o  out  KEEP_WIDTH  byte-valid mask, contiguous from bit 0
- m_last_o  out  1  final beat
- m_valid_o  out  1  beat valid
- m_ready_i  in  1  consumer ready
- busy_o  out  1  squeeze in progress
- done_o  out  1  one-cycle completion pulse

Function
REQ-003 SHALL implement states IDLE, EMIT and PERM_WAIT.
REQ-004 IDLE: start_i with out_len_i>0 SHALL latch rate and length, clear block offset, and enter EMIT; start_i with out_len_i==0 SHALL pulse done_o next cycle and emit no beat.
REQ-005 start_i while busy_o=1 SHALL be ignored.
REQ-006 Lane L SHALL map to state_array_i[L%5][L/5]; beat lane k (0..3) is L=offset/8+k, placed at m_data_o[64k+:64].
REQ-007 Beat bytes SHALL be n=min(32, rate/8−offset, remaining); m_keep_o=(1<<n)−1; data bytes outside keep SHALL be zero.
REQ-008 Beats SHALL NOT span blocks; lanes at or beyond rate/64 SHALL contribute zero.
REQ-009 m_valid_o, m_data_o, m_keep_o and m_last_o SHALL be registered; m_valid_o SHALL rise in the cycle after start is accepted or perm_done_i is sampled.
REQ-010 While m_valid_o=1 and m_ready_i=0, all m_* outputs SHALL be held stable.
REQ-011 On m_valid_o && m_ready_i, offset SHALL advance by n and remaining SHALL decrement by n; the next beat SHALL be presented in the following cycle with no bubble.
REQ-012 m_last_o SHALL be 1 iff the beat makes remaining reach 0; on its acceptance the block SHALL return to IDLE and pulse done_o for 1 cycle.
REQ-013 When offset reaches rate/8 with remaining>0, the block SHALL deassert m_valid_o, enter PERM_WAIT, and assert perm_req_o until perm_done_i is sampled high, then reset offset to 0 and return to EMIT.
REQ-014 perm_done_i outside PERM_WAIT SHALL be ignored.
REQ-015 busy_o SHALL be 1 in EMIT and PERM_WAIT.
REQ-016 state_array_i SHALL be sampled only when a beat is loaded.

Reset
REQ-017 rst_n=0 SHALL asynchronously force IDLE, clear offset and remaining, and drive m_valid_o, m_keep_o, m_data_o, m_last_o, perm_req_o, busy_o and done_o to 0, including mid-beat and mid-PERM_WAIT.
REQ-018 After rst_n deasserts, the first start_i SHALL be accepted in the first clk edge.

Configuration
REQ-019 With KECCAK_SQUEEZE_XOF_EN defined, an extra input stop_i SHALL exist; out_len_i==0 SHALL then mean unbounded output: n=min(32, rate/8−offset), and m_last_o SHALL never assert. stop_i=1 SHALL return the block to IDLE at the next clk edge, dropping any pending beat, with a done_o pulse.
REQ-020 Without KECCAK_SQUEEZE_XOF_EN, stop_i SHALL be absent and REQ-004 zero-length behaviour SHALL apply.

Verification
REQ-021 Rate 1088 with out_len 32 -> one beat, keep 0xFFFFFFFF, last=1, lanes 0–3; no perm_req_o; done_o one cycle after acceptance.
REQ-022 Rate 1344 with out_len 180 -> five beats of keep 0xFFFFFFFF then keep 0x000000FF (lane 20); perm_req_o until perm_done_i; then keep 0x00000FFF, last=1.
REQ-023 m_ready_i low for 3 cycles mid-stream -> m_* outputs unchanged, no byte lost or duplicated.
REQ-024 rst_n asserted during PERM_WAIT -> perm_req_o and busy_o are 0 immediately; a new start_i produces a correct stream.
REQ-025 out_len 0 without XOF_EN -> no m_valid_o, done_o pulses one cycle after start_i; start_i while busy_o=1 is ignored.
REQ-026 With XOF_EN, rate 1344 and out_len 0 -> continuous beats across 3 permutations; stop_i -> IDLE next cycle with done_o pulse.
